// File: rtl/swan256_word_loader.sv
// Word-serial loader/drainer for the serial SWAN256 cores: gathers 8 key + 8 data words, starts the core, streams 8 result words.
// Optional key reuse across blocks is enabled by defining SWAN256_KEY_REUSE_EN.
module swan256_word_loader #(
  parameter int BLOCK_SIZE = 256,
  parameter int KEY_SIZE   = 256,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_is_key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic                  core_start,
  output logic [0:BLOCK_SIZE-1] core_inp,
  output logic [0:KEY_SIZE-1]   core_key,
  input  logic                  core_ready,
  input  logic [0:BLOCK_SIZE-1] core_out,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [3:0]            key_cnt_q, key_cnt_d;
  logic [3:0]            dat_cnt_q, dat_cnt_d;
  logic [2:0]            out_cnt_q, out_cnt_d;
  logic [15:0]           timer_q, timer_d;
  logic [0:KEY_SIZE-1]   key_q, key_d;
  logic [0:BLOCK_SIZE-1] inp_q, inp_d;
  logic [0:BLOCK_SIZE-1] res_q, res_d;
  logic                  err_q, err_d;
  logic                  key_full, dat_full, key_room, accept;
  logic [2:0]            key_idx;
`ifdef SWAN256_KEY_REUSE_EN
  logic                  key_valid_q, key_valid_d;
`endif

  always_comb begin
    state_d   = state_q;
    key_cnt_d = key_cnt_q;
    dat_cnt_d = dat_cnt_q;
    out_cnt_d = out_cnt_q;
    timer_d   = timer_q;
    key_d     = key_q;
    inp_d     = inp_q;
    res_d     = res_q;
    err_d     = err_q;
    key_full  = (key_cnt_q == 4'd8);
    dat_full  = (dat_cnt_q == 4'd8);
`ifdef SWAN256_KEY_REUSE_EN
    // A retained key still counts as full, but a new key word restarts loading at index 0.
    key_valid_d = key_valid_q;
    key_room    = !key_full || key_valid_q;
    key_idx     = key_valid_q ? 3'd0 : key_cnt_q[2:0];
`else
    key_room    = !key_full;
    key_idx     = key_cnt_q[2:0];
`endif
    in_ready = (state_q == S_LOAD) && (in_is_key ? key_room : !dat_full);
    accept   = in_valid && in_ready;

    case (state_q)
      S_LOAD: begin
        if (accept && in_is_key) begin
          key_d[{key_idx, 5'd0} +: 32] = in_data;
          key_cnt_d = {1'b0, key_idx} + 4'd1;
`ifdef SWAN256_KEY_REUSE_EN
          key_valid_d = 1'b0;
`endif
        end
        if (accept && !in_is_key) begin
          inp_d[{dat_cnt_q[2:0], 5'd0} +: 32] = in_data;
          dat_cnt_d = dat_cnt_q + 4'd1;
        end
        if (key_cnt_d == 4'd8 && dat_cnt_d == 4'd8) state_d = S_START;
      end
      S_START: begin
        timer_d = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // core_ready takes priority over an expiring timer.
        if (core_ready) begin
          res_d     = core_out;
          out_cnt_d = 3'd0;
          state_d   = S_DRAIN;
        end else if (timer_q == TIMER_LAST) begin
          err_d     = 1'b1;
          key_cnt_d = 4'd0;
          dat_cnt_d = 4'd0;
`ifdef SWAN256_KEY_REUSE_EN
          key_valid_d = 1'b0;
`endif
          state_d   = S_LOAD;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (out_cnt_q == 3'd7) begin
            dat_cnt_d = 4'd0;
`ifdef SWAN256_KEY_REUSE_EN
            key_valid_d = 1'b1;
`else
            key_cnt_d = 4'd0;
`endif
            state_d = S_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_LOAD;
      key_cnt_q <= 4'd0;
      dat_cnt_q <= 4'd0;
      out_cnt_q <= 3'd0;
      timer_q   <= 16'd0;
      key_q     <= '0;
      inp_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
`ifdef SWAN256_KEY_REUSE_EN
      key_valid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_cnt_q <= key_cnt_d;
      dat_cnt_q <= dat_cnt_d;
      out_cnt_q <= out_cnt_d;
      timer_q   <= timer_d;
      key_q     <= key_d;
      inp_q     <= inp_d;
      res_q     <= res_d;
      err_q     <= err_d;
`ifdef SWAN256_KEY_REUSE_EN
      key_valid_q <= key_valid_d;
`endif
    end
  end

  assign out_valid   = (state_q == S_DRAIN);
  assign out_data    = out_valid ? res_q[{out_cnt_q, 5'd0} +: 32] : 32'd0;
  assign out_last    = out_valid && (out_cnt_q == 3'd7);
  assign core_start  = (state_q == S_START);
  assign core_inp    = inp_q;
  assign core_key    = key_q;
  assign busy        = (state_q != S_LOAD);
  assign timeout_err = err_q;

endmodule

// File: doc/swan256_word_loader.md
Name: swan256_word_loader

Overview:
- Word-serial front end for the serial SWAN256 cipher cores (serial_SWAN256_ENC / serial_SWAN256_DEC).
- Collects eight 32-bit key words and eight 32-bit data words from a valid/ready stream, then drives the core's start/inp/key.
- Waits for the core's ready and streams the 256-bit result back out as eight 32-bit words.
- Replaces the behavioural bench driver with synthesizable hardware, for on-chip bring-up and bus attachment.

Parameters:
- BLOCK_SIZE, 256, data block width in bits; fixed, must equal 8*32.
- KEY_SIZE, 256, key width in bits; fixed, must equal 8*32.
- TIMEOUT, 1024, maximum cycles to wait for core_ready before the block is flagged as an error; range 2..65535.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  32  input word.
- in_is_key  in  1  1 = key word, 0 = data word.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_data  out  32  result word.
- out_last  out  1  high with the 8th result word.
- core_start  out  1  start pulse to the core.
- core_inp  out  [0:BLOCK_SIZE-1]  data block to the core.
- core_key  out  [0:KEY_SIZE-1]  key to the core.
- core_ready  in  1  core done; core_out is valid while this is high.
- core_out  in  [0:BLOCK_SIZE-1]  core result.
- busy  out  1  high in every state except LOAD.
- timeout_err  out  1  sticky error flag; cleared by reset only.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=LOAD; all outputs 0 except in_ready=1;
  - key_cnt=0, dat_cnt=0, key_valid=0;
  - core_inp/core_key registers=0.
- Word order: word n maps to bits [32n : 32n+31]. Word 0 is the most-significant word, i.e. the leftmost hex digits of a vector.
- LOAD:
  - in_ready = !(in_is_key ? key_full : dat_full). This is combinational on in_is_key.
  - Each accepted word is written at index key_cnt or dat_cnt, and that counter increments.
  - key_full when key_cnt==8; dat_full when dat_cnt==8. Key and data words may interleave in any order.
  - When both are full (including on the accepting edge), go to START on the next edge.
- START: core_start=1 for exactly one cycle. core_inp and core_key are held stable from here until core_ready is sampled. Next state is WAIT.
- WAIT:
  - Timer counts up from 0.
  - If core_ready=1: capture core_out into the output register, go to DRAIN.
  - If the timer reaches TIMEOUT-1 with core_ready=0: set timeout_err and go to LOAD with counters cleared. No output words are produced.
  - If core_ready is high in the same cycle the timer expires, core_ready wins.
- DRAIN:
  - out_valid=1; out_data = word[out_cnt].
  - On out_valid && out_ready, out_cnt increments. out_last=1 when out_cnt==7.
  - After the 8th transfer: clear dat_cnt and key_cnt, then go to LOAD. The first in_ready is high the cycle after.
  - out_valid and out_data stay stable while out_ready=0.
- Latency: 8th input accepted at edge T → core_start high in cycle T+1. core_ready sampled at edge R → out_valid high in cycle R+1.
- Reset asserted mid-block (any state) aborts immediately. Nothing is emitted; state returns to LOAD.
- A core_ready pulse seen outside WAIT is ignored.

Optional Feature:
- Macro SWAN256_KEY_REUSE_EN.
- Defined:
  - After a block, key_cnt is not cleared; key_valid stays 1 and key_full is treated as true. Following blocks need only 8 data words.
  - The first key word accepted after a completed block clears key_valid and key_cnt. The core then waits for a full new 8-word key; that word is stored as index 0.
- Undefined: every block requires 8 key words plus 8 data words, and key_valid logic is absent.

Test Plan:
- Encrypt path with the ENC core:
  - Stimulus: key words all ffffffff; data words f0debc9a,78563412 repeated 4×.
  - Required response: 8 output words 5e7f7837, ab855ba2, 666046be, 47c2b93a, 435db796, 15506e31, 28b7fd3d, 1a0f22c2; out_last on the 8th; core_start high exactly one cycle.
- Decrypt path with the DEC core:
  - Stimulus: key 0; data 7bfc52c9 … 20e3775c.
  - Required response: output 78563412 ×8.
- Backpressure:
  - Stimulus: out_ready toggled 1-in-3 during DRAIN; in_valid given one word every other cycle, key and data interleaved.
  - Required response: same words as the encrypt test, out_data stable while stalled, no word dropped or duplicated.
- Timeout:
  - Stimulus: core_ready stub held 0, TIMEOUT=16.
  - Required response: timeout_err=1 exactly 16 cycles after START; state returns to LOAD with in_ready=1 and no out_valid.
- Reset mid-WAIT:
  - Stimulus: rst pulsed low for 3 cycles.
  - Required response: all outputs reset asynchronously; a following full encrypt block gives the correct result.
- Key reuse:
  - Stimulus: with SWAN256_KEY_REUSE_EN defined, key 7856341278563412… is loaded once, then two blocks are sent with data only (2222…1111, then the same again).
  - Required response: output 5a1c0060 … c5cb5961 both times.
  - With the macro undefined, the second data-only block must stall in LOAD (busy=0, no core_start).
